// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: IR/memory-ready inputs and every datapath strobe.
// The control unit drives through the master modport; the datapath side uses slave.
interface multicycle_control_unit_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] inst;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic [1:0]           pc_source;
    logic                 ir_write;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic [1:0]           reg_dst;
    logic [1:0]           wb_sel;
    logic [1:0]           alu_src_b;
    logic                 output_en;
    logic                 is_halted;
    logic [WORD_SIZE-1:0] num_inst;

    modport master (
        input  inst, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
               mem_write, reg_write, reg_dst, wb_sel, alu_src_b, output_en,
               is_halted, num_inst
    );

    modport slave (
        output inst, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
               mem_write, reg_write, reg_dst, wb_sel, alu_src_b, output_en,
               is_halted, num_inst
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with memory-ready waits,
// retired-instruction counter and HLT absorbing state.
module multicycle_control_unit #(
    parameter int WORD_SIZE = 16,
    parameter int OPCODE_W  = 4,
    parameter int FUNC_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    multicycle_control_unit_if.master   bus
);
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_BLZ   = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_ADI   = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_LHI   = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_LWD   = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_SWD   = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'd15;

    localparam logic [FUNC_W-1:0] FN_SHR = 6'd9;
    localparam logic [FUNC_W-1:0] FN_JPR = 6'd25;
    localparam logic [FUNC_W-1:0] FN_JRL = 6'd26;
    localparam logic [FUNC_W-1:0] FN_WWD = 6'd28;
    localparam logic [FUNC_W-1:0] FN_HLT = 6'd29;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

    logic [OPCODE_W-1:0]  opcode_s;
    logic [FUNC_W-1:0]    func_s;
    logic                 is_branch_s, is_rtype_s, is_r_alu_s, func_valid_s, op_valid_s;
    logic                 unused_inst_s;

    logic                 retire_s;
    logic                 pc_write_s, pc_write_cond_s, ir_write_s, i_or_d_s;
    logic                 mem_read_s, mem_write_s, reg_write_s, output_en_s, is_halted_s;
    logic [1:0]           pc_source_s, reg_dst_s, wb_sel_s, alu_src_b_s;

    assign opcode_s      = bus.inst[WORD_SIZE-1 -: OPCODE_W];
    assign func_s        = bus.inst[FUNC_W-1:0];
    assign unused_inst_s = ^bus.inst[WORD_SIZE-OPCODE_W-1:FUNC_W];

    // Instruction classification from the IR fields.
    always_comb begin
        is_branch_s  = (opcode_s <= OP_BLZ);
        is_rtype_s   = (opcode_s == OP_RTYPE);
        is_r_alu_s   = is_rtype_s && (func_s <= FN_SHR);
        func_valid_s = (func_s <= FN_SHR) || (func_s == FN_JPR) || (func_s == FN_JRL) ||
                       (func_s == FN_WWD) || (func_s == FN_HLT);
        op_valid_s   = (opcode_s <= OP_JAL) || (is_rtype_s && func_valid_s);
    end

    // Next-state, retire and strobe decode.
    always_comb begin
        state_d         = state_q;
        retire_s        = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_source_s     = 2'd0;
        ir_write_s      = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        reg_dst_s       = 2'd0;
        wb_sel_s        = 2'd0;
        alu_src_b_s     = 2'd0;
        output_en_s     = 1'b0;
        is_halted_s     = 1'b0;

        case (state_q)
            ST_IF: begin
                mem_read_s = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_ID;
                end else begin
                    state_d    = ST_IF;
                end
            end
            ST_ID: begin
                if (!op_valid_s) begin
                    retire_s = 1'b1;
                    state_d  = ST_IF;
                end else if (opcode_s == OP_JMP || opcode_s == OP_JAL) begin
                    pc_write_s  = 1'b1;
                    pc_source_s = 2'd2;
                    if (opcode_s == OP_JAL) begin
                        reg_write_s = 1'b1;
                        reg_dst_s   = 2'd2;
                        wb_sel_s    = 2'd2;
                    end else begin
                        reg_write_s = 1'b0;
                    end
                    retire_s = 1'b1;
                    state_d  = ST_IF;
                end else if (is_rtype_s && func_s == FN_HLT) begin
                    retire_s = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d  = ST_EX;
                end
            end
            ST_EX: begin
                if (is_branch_s) begin
                    pc_write_cond_s = 1'b1;
                    pc_source_s     = 2'd1;
                    retire_s        = 1'b1;
                    state_d         = ST_IF;
                end else if (is_rtype_s && (func_s == FN_JPR || func_s == FN_JRL)) begin
                    pc_write_s  = 1'b1;
                    pc_source_s = 2'd3;
                    if (func_s == FN_JRL) begin
                        reg_write_s = 1'b1;
                        reg_dst_s   = 2'd2;
                        wb_sel_s    = 2'd2;
                    end else begin
                        reg_write_s = 1'b0;
                    end
                    retire_s = 1'b1;
                    state_d  = ST_IF;
                end else if (is_rtype_s && func_s == FN_WWD) begin
                    output_en_s = 1'b1;
                    retire_s    = 1'b1;
                    state_d     = ST_IF;
                end else if (opcode_s == OP_LWD || opcode_s == OP_SWD) begin
                    alu_src_b_s = 2'd1;
                    state_d     = ST_MEM;
                end else if (opcode_s == OP_ADI) begin
                    alu_src_b_s = 2'd1;
                    state_d     = ST_WB;
                end else if (opcode_s == OP_ORI) begin
                    alu_src_b_s = 2'd2;
                    state_d     = ST_WB;
                end else if (opcode_s == OP_LHI) begin
                    alu_src_b_s = 2'd3;
                    state_d     = ST_WB;
                end else if (is_r_alu_s) begin
                    state_d     = ST_WB;
                end else begin
                    // Unreachable with a stable IR; retire rather than hang.
                    retire_s    = 1'b1;
                    state_d     = ST_IF;
                end
            end
            ST_MEM: begin
                i_or_d_s = 1'b1;
                if (opcode_s == OP_LWD) begin
                    mem_read_s = 1'b1;
                    state_d    = bus.mem_ready ? ST_WB : ST_MEM;
                end else if (opcode_s == OP_SWD) begin
                    mem_write_s = 1'b1;
                    retire_s    = bus.mem_ready;
                    state_d     = bus.mem_ready ? ST_IF : ST_MEM;
                end else begin
                    retire_s = 1'b1;
                    state_d  = ST_IF;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                if (opcode_s == OP_LWD) begin
                    wb_sel_s = 2'd1;
                end else if (is_rtype_s) begin
                    reg_dst_s = 2'd1;
                end else begin
                    reg_dst_s = 2'd0;
                end
                retire_s = 1'b1;
                state_d  = ST_IF;
            end
            ST_HALT: begin
                is_halted_s = 1'b1;
                state_d     = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    // Retired-instruction counter, wrapping naturally at 2^WORD_SIZE.
    always_comb begin
        num_inst_d = num_inst_q + WORD_SIZE'(retire_s);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IF;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            num_inst_q <= num_inst_d;
        end
    end

    // Strobes are forced low while reset is held so nothing leaks mid-abort.
    assign bus.pc_write      = reset_n & pc_write_s;
    assign bus.pc_write_cond = reset_n & pc_write_cond_s;
    assign bus.pc_source     = reset_n ? pc_source_s : 2'd0;
    assign bus.ir_write      = reset_n & ir_write_s;
    assign bus.i_or_d        = reset_n & i_or_d_s;
    assign bus.mem_read      = reset_n & mem_read_s;
    assign bus.mem_write     = reset_n & mem_write_s;
    assign bus.reg_write     = reset_n & reg_write_s;
    assign bus.reg_dst       = reset_n ? reg_dst_s : 2'd0;
    assign bus.wb_sel        = reset_n ? wb_sel_s : 2'd0;
    assign bus.alu_src_b     = reset_n ? alu_src_b_s : 2'd0;
    assign bus.output_en     = reset_n & output_en_s;
    assign bus.is_halted     = reset_n & is_halted_s;
    assign bus.num_inst      = num_inst_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle strobe vectors and
// retire counts against hand-computed expectations.
module tb_multicycle_control_unit;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    int   pwc_cnt;
    int   oen_cnt;

    multicycle_control_unit_if #(.WORD_SIZE(16)) bus ();

    multicycle_control_unit #(.WORD_SIZE(16), .OPCODE_W(4), .FUNC_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
    //  reg_write, reg_dst, wb_sel, alu_src_b, output_en, is_halted}
    logic [16:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write, bus.i_or_d,
                  bus.mem_read, bus.mem_write, bus.reg_write, bus.reg_dst, bus.wb_sel,
                  bus.alu_src_b, bus.output_en, bus.is_halted};

    function automatic logic [16:0] ev(input logic pw, input logic pwc, input logic [1:0] psrc,
                                       input logic irw, input logic iod, input logic mr,
                                       input logic mw, input logic rw, input logic [1:0] rdst,
                                       input logic [1:0] wsel, input logic [1:0] asb,
                                       input logic oen, input logic hlt);
        return {pw, pwc, psrc, irw, iod, mr, mw, rw, rdst, wsel, asb, oen, hlt};
    endfunction

    logic [16:0] e_zero, e_if_hit, e_if_wait;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.inst = 16'hF1C0;
        #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL reset_strobes: got %h expected %h", obs, e_zero); end
        tick();
        checks++;
        if (bus.num_inst !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.num_inst); end
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs !== e_if_hit) begin errors++; $display("FAIL reset_release_if: got %h expected %h", obs, e_if_hit); end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [16:0] e_wb;
        e_wb = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
        bus.inst = 16'hF1C0;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== e_if_hit) begin errors++; $display("FAIL add_if: got %h expected %h", obs, e_if_hit); end
        tick(); #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL add_id: got %h expected %h", obs, e_zero); end
        tick(); #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL add_ex: got %h expected %h", obs, e_zero); end
        tick(); #1;
        checks++;
        if (obs !== e_wb) begin errors++; $display("FAIL add_wb: got %h expected %h", obs, e_wb); end
        tick(); bus.mem_ready = 1'b0; #1;
        checks++;
        if (obs !== e_if_wait) begin errors++; $display("FAIL add_back_in_if: got %h expected %h", obs, e_if_wait); end
        checks++;
        if (bus.num_inst !== 16'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", bus.num_inst); end
    endtask

    task automatic test_lwd();
        logic [16:0] e_ex, e_mem, e_wb;
        e_ex  = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        e_mem = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        e_wb  = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
        bus.inst = 16'h7101;
        for (int i = 0; i < 2; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (obs !== e_if_wait) begin errors++; $display("FAIL lwd_if_wait%0d: got %h expected %h", i, obs, e_if_wait); end
            tick();
        end
        bus.mem_ready = 1'b1; #1;
        checks++;
        if (obs !== e_if_hit) begin errors++; $display("FAIL lwd_if_hit: got %h expected %h", obs, e_if_hit); end
        tick(); #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL lwd_id: got %h expected %h", obs, e_zero); end
        tick(); #1;
        checks++;
        if (obs !== e_ex) begin errors++; $display("FAIL lwd_ex: got %h expected %h", obs, e_ex); end
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3) ? 1'b1 : 1'b0;
            #1;
            checks++;
            if (obs !== e_mem) begin errors++; $display("FAIL lwd_mem%0d: got %h expected %h", i, obs, e_mem); end
            tick();
        end
        #1;
        checks++;
        if (obs !== e_wb) begin errors++; $display("FAIL lwd_wb: got %h expected %h", obs, e_wb); end
        tick(); bus.mem_ready = 1'b0; #1;
        checks++;
        if (obs !== e_if_wait || bus.num_inst !== 16'd2) begin
            errors++; $display("FAIL lwd_done: got %h/%0d expected %h/2", obs, bus.num_inst, e_if_wait);
        end
    endtask

    task automatic test_jal();
        logic [16:0] e_id;
        e_id = ev(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0);
        bus.inst = 16'hA010;
        bus.mem_ready = 1'b1; #1;
        checks++;
        if (obs !== e_if_hit) begin errors++; $display("FAIL jal_if: got %h expected %h", obs, e_if_hit); end
        tick(); #1;
        checks++;
        if (obs !== e_id) begin errors++; $display("FAIL jal_id: got %h expected %h", obs, e_id); end
        tick(); bus.mem_ready = 1'b0; #1;
        checks++;
        if (obs !== e_if_wait || bus.num_inst !== 16'd3) begin
            errors++; $display("FAIL jal_done: got %h/%0d expected %h/3", obs, bus.num_inst, e_if_wait);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e_beq, e_wwd, e_swd_ex, e_swd_mem;
        e_beq     = ev(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        e_wwd     = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        e_swd_ex  = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        e_swd_mem = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        do_reset();
        pwc_cnt = 0;
        oen_cnt = 0;
        // BEQ: IF, ID, EX
        bus.inst = 16'h1204;
        for (int c = 0; c < 3; c++) begin
            #1;
            pwc_cnt += int'(bus.pc_write_cond);
            oen_cnt += int'(bus.output_en);
            if (c == 2) begin
                checks++;
                if (obs !== e_beq) begin errors++; $display("FAIL beq_ex: got %h expected %h", obs, e_beq); end
            end
            tick();
        end
        // WWD: IF, ID, EX
        bus.inst = 16'hF01C;
        for (int c = 0; c < 3; c++) begin
            #1;
            pwc_cnt += int'(bus.pc_write_cond);
            oen_cnt += int'(bus.output_en);
            if (c == 2) begin
                checks++;
                if (obs !== e_wwd) begin errors++; $display("FAIL wwd_ex: got %h expected %h", obs, e_wwd); end
            end
            tick();
        end
        // SWD: IF, ID, EX, then MEM with two wait cycles
        bus.inst = 16'h8101;
        for (int c = 0; c < 6; c++) begin
            bus.mem_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            #1;
            pwc_cnt += int'(bus.pc_write_cond);
            oen_cnt += int'(bus.output_en);
            if (c == 2) begin
                checks++;
                if (obs !== e_swd_ex) begin errors++; $display("FAIL swd_ex: got %h expected %h", obs, e_swd_ex); end
            end else if (c >= 3) begin
                checks++;
                if (obs !== e_swd_mem) begin errors++; $display("FAIL swd_mem%0d: got %h expected %h", c, obs, e_swd_mem); end
            end
            tick();
        end
        bus.mem_ready = 1'b0; #1;
        checks++;
        if (pwc_cnt !== 1) begin errors++; $display("FAIL pwc_pulses: got %0d expected 1", pwc_cnt); end
        checks++;
        if (oen_cnt !== 1) begin errors++; $display("FAIL oen_pulses: got %0d expected 1", oen_cnt); end
        checks++;
        if (obs !== e_if_wait || bus.num_inst !== 16'd3) begin
            errors++; $display("FAIL seq_done: got %h/%0d expected %h/3", obs, bus.num_inst, e_if_wait);
        end
    endtask

    task automatic test_undefined();
        // Undefined opcode 11, then R-type with undefined func 63: both are 2-cycle NOPs.
        bus.inst = 16'hB000;
        bus.mem_ready = 1'b1;
        tick(); #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL undef_op_id: got %h expected %h", obs, e_zero); end
        tick();
        bus.inst = 16'hF03F; #1;
        checks++;
        if (obs !== e_if_hit || bus.num_inst !== 16'd4) begin
            errors++; $display("FAIL undef_op_done: got %h/%0d expected %h/4", obs, bus.num_inst, e_if_hit);
        end
        tick(); tick(); #1;
        checks++;
        if (obs !== e_if_hit || bus.num_inst !== 16'd5) begin
            errors++; $display("FAIL undef_func_done: got %h/%0d expected %h/5", obs, bus.num_inst, e_if_hit);
        end
    endtask

    task automatic test_halt();
        logic [16:0] e_halt;
        int bad;
        e_halt = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
        bus.inst = 16'hF01D;
        bus.mem_ready = 1'b1;
        tick(); #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL hlt_id: got %h expected %h", obs, e_zero); end
        tick();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (obs !== e_halt) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hlt_hold: got %0d bad cycles expected 0", bad); end
        checks++;
        if (bus.num_inst !== 16'd6) begin errors++; $display("FAIL hlt_count: got %0d expected 6", bus.num_inst); end
    endtask

    task automatic test_mid_reset();
        logic [16:0] e_swd_mem;
        e_swd_mem = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        do_reset();
        bus.inst = 16'h9000;
        tick(); tick();
        bus.inst = 16'h8101;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0; #1;
        checks++;
        if (obs !== e_swd_mem || bus.num_inst !== 16'd1) begin
            errors++; $display("FAIL midrst_pre: got %h/%0d expected %h/1", obs, bus.num_inst, e_swd_mem);
        end
        reset_n = 1'b0; #1;
        checks++;
        if (obs !== e_zero) begin errors++; $display("FAIL midrst_strobes: got %h expected %h", obs, e_zero); end
        checks++;
        if (bus.num_inst !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.num_inst); end
        tick(); tick();
        bus.mem_ready = 1'b1;
        reset_n = 1'b1; #1;
        checks++;
        if (obs !== e_if_hit) begin errors++; $display("FAIL midrst_release: got %h expected %h", obs, e_if_hit); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        bus.inst = 16'h0000;
        bus.mem_ready = 1'b0;
        e_zero    = 17'd0;
        e_if_hit  = ev(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        e_if_wait = ev(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        #3;
        test_reset();
        test_add();
        test_lwd();
        test_jal();
        test_back_to_back();
        test_undefined();
        test_halt();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
